// File: rtl/median_filter.sv
// Streaming WINDOW_SIZE x WINDOW_SIZE per-channel median filter for raster-order RGB pixels.
// Line buffers feed a sliding window; the median is selected by rank counting, with a fixed 2-clock latency.
module median_filter #(
    parameter int WINDOW_SIZE = 5,
    parameter int DATA_WIDTH  = 8,
    parameter int img_width   = 229,
    parameter int img_height  = 229,
    parameter int NUM_PIXELS  = img_width * img_height
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [3*DATA_WIDTH-1:0] new_pixel,
    input  logic                    more_pixels,
    input  logic                    rdy,
    input  logic [31:0]             max_windows,
    output logic [3*DATA_WIDTH-1:0] median_out,
    output logic                    ready,
    output logic                    finished
);
    localparam int PW   = 3 * DATA_WIDTH;
    localparam int NW   = WINDOW_SIZE * WINDOW_SIZE;
    localparam int CNTW = $clog2(NW + 1);
    localparam int CLW  = (img_width > 1) ? $clog2(img_width) : 1;
    localparam int RWW  = (img_height > 1) ? $clog2(img_height + 1) : 1;

    localparam logic [CNTW-1:0] MID       = CNTW'((NW - 1) / 2);
    localparam logic [CLW-1:0]  COL_LAST  = CLW'(img_width - 1);
    localparam logic [CLW-1:0]  COL_WIN   = CLW'(WINDOW_SIZE - 1);
    localparam logic [RWW-1:0]  ROW_WIN   = RWW'(WINDOW_SIZE - 1);

    logic [PW-1:0]            r_line [WINDOW_SIZE-1][img_width];
    logic [PW-1:0]            r_win  [WINDOW_SIZE][WINDOW_SIZE];
    logic [31:0]              r_pix_cnt;
    logic [CLW-1:0]           r_col;
    logic [RWW-1:0]           r_row;
    logic [31:0]              r_out_cnt;
    logic                     r_v0;
    logic                     r_v1;
    logic [PW-1:0]            r_med_s1;

    logic                     w_accept;
    logic                     w_win_done;
    logic                     w_room;
    logic [NW*DATA_WIDTH-1:0] w_flat [3];
    logic [PW-1:0]            w_med;
    logic                     w_unused;

    assign w_unused   = rdy;
    assign w_accept   = more_pixels && (r_pix_cnt < NUM_PIXELS);
    assign w_win_done = (r_row >= ROW_WIN) && (r_col >= COL_WIN);
    assign w_room     = r_out_cnt < max_windows;

    // An element is the median when fewer than MID+1 values are strictly below it
    // and more than MID values are at or below it; all such elements share one value.
    function automatic logic [DATA_WIDTH-1:0] f_median(input logic [NW*DATA_WIDTH-1:0] v);
        logic [DATA_WIDTH-1:0] res;
        logic [CNTW-1:0]       n_lt;
        logic [CNTW-1:0]       n_le;
        res = '0;
        for (int i = 0; i < NW; i++) begin
            n_lt = '0;
            n_le = '0;
            for (int j = 0; j < NW; j++) begin
                n_lt = n_lt + CNTW'(v[j*DATA_WIDTH +: DATA_WIDTH] <  v[i*DATA_WIDTH +: DATA_WIDTH]);
                n_le = n_le + CNTW'(v[j*DATA_WIDTH +: DATA_WIDTH] <= v[i*DATA_WIDTH +: DATA_WIDTH]);
            end
            if ((n_lt <= MID) && (n_le > MID)) begin
                res = res | v[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        return res;
    endfunction

    always_comb begin
        for (int ch = 0; ch < 3; ch++) begin
            w_flat[ch] = '0;
        end
        for (int ch = 0; ch < 3; ch++) begin
            for (int i = 0; i < WINDOW_SIZE; i++) begin
                for (int j = 0; j < WINDOW_SIZE; j++) begin
                    w_flat[ch][(i*WINDOW_SIZE+j)*DATA_WIDTH +: DATA_WIDTH] =
                        r_win[i][j][ch*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    assign w_med = {f_median(w_flat[2]), f_median(w_flat[1]), f_median(w_flat[0])};

    // Row 0 of the window and line buffer 0 hold the oldest image row.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            for (int k = 0; k < WINDOW_SIZE-2; k++) begin
                r_line[k][r_col] <= r_line[k+1][r_col];
            end
            r_line[WINDOW_SIZE-2][r_col] <= new_pixel;
            for (int i = 0; i < WINDOW_SIZE; i++) begin
                for (int j = 0; j < WINDOW_SIZE-1; j++) begin
                    r_win[i][j] <= r_win[i][j+1];
                end
            end
            for (int i = 0; i < WINDOW_SIZE-1; i++) begin
                r_win[i][WINDOW_SIZE-1] <= r_line[i][r_col];
            end
            r_win[WINDOW_SIZE-1][WINDOW_SIZE-1] <= new_pixel;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pix_cnt  <= '0;
            r_col      <= '0;
            r_row      <= '0;
            r_out_cnt  <= '0;
            r_v0       <= 1'b0;
            r_v1       <= 1'b0;
            r_med_s1   <= '0;
            median_out <= '0;
            ready      <= 1'b0;
            finished   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_pix_cnt <= r_pix_cnt + 32'd1;
                if (r_col == COL_LAST) begin
                    r_col <= '0;
                    r_row <= r_row + RWW'(1);
                end else begin
                    r_col <= r_col + CLW'(1);
                end
            end
            r_v0     <= w_accept && w_win_done;
            r_v1     <= r_v0;
            r_med_s1 <= w_med;
            if (r_v1 && w_room) begin
                ready      <= 1'b1;
                median_out <= r_med_s1;
                r_out_cnt  <= r_out_cnt + 32'd1;
            end else begin
                ready <= 1'b0;
            end
            if (r_out_cnt >= max_windows) begin
                finished <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_median_filter.sv
// Randomised scoreboard bench for median_filter on a small frame: a sort-based model predicts
// every median and the edge it should appear on; a monitor pops and compares on each ready pulse.
module tb_median_filter;
    localparam int WS   = 5;
    localparam int DW   = 8;
    localparam int W    = 11;
    localparam int H    = 8;
    localparam int P    = WS / 2;
    localparam int NWIN = (H - 2*P) * (W - 2*P);

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [23:0] new_pixel = '0;
    logic        more_pixels = 1'b0;
    logic        rdy = 1'b0;
    logic [31:0] max_windows = NWIN;
    logic [23:0] median_out;
    logic        ready;
    logic        finished;

    median_filter #(
        .WINDOW_SIZE(WS),
        .DATA_WIDTH (DW),
        .img_width  (W),
        .img_height (H)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .new_pixel  (new_pixel),
        .more_pixels(more_pixels),
        .rdy        (rdy),
        .max_windows(max_windows),
        .median_out (median_out),
        .ready      (ready),
        .finished   (finished)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          checks = 0;
    int          errors = 0;
    logic [23:0] img [H][W];
    logic [23:0] exp_val [$];
    int          exp_cyc [$];
    int          pushed = 0;
    int          pulses = 0;
    logic [23:0] last_val = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (ready === 1'b1) begin
            pulses++;
            if (exp_val.size() == 0) begin
                check("spurious_ready", {31'd0, ready}, 32'd0);
            end else begin
                logic [23:0] v;
                int          c;
                v = exp_val.pop_front();
                c = exp_cyc.pop_front();
                check("median_value", {8'd0, median_out}, {8'd0, v});
                check("median_latency", cyc, c);
                last_val = v;
            end
        end
    end

    function automatic logic [23:0] model_median(input int r, input int c);
        int          q [$];
        int          t;
        logic [23:0] res;
        res = '0;
        for (int ch = 0; ch < 3; ch++) begin
            q.delete();
            for (int dr = 0; dr < WS; dr++)
                for (int dc = 0; dc < WS; dc++)
                    q.push_back(int'((img[r-WS+1+dr][c-WS+1+dc] >> (8*ch)) & 24'hFF));
            q.sort();
            t = q[(WS*WS-1)/2];
            res[8*ch +: 8] = 8'(t);
        end
        return res;
    endfunction

    task automatic fill_img(input int mode);
        logic [7:0] red;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                red = 8'(r*W + c);
                case (mode)
                    0: img[r][c] = 24'h204060;
                    1: img[r][c] = {red, 8'h55, 8'hFF - red};
                    2: img[r][c] = 24'($urandom);
                    3: img[r][c] = ((r % 3 == 1) && (c % 4 == 2)) ?
                                   (($urandom_range(0, 1) == 1) ? 24'hFFFFFF : 24'h000000) : 24'h101010;
                    default: img[r][c] = {8'($urandom_range(0, 3)), 8'($urandom_range(0, 3)),
                                          8'($urandom_range(0, 3))};
                endcase
            end
        end
    endtask

    task automatic stall(input int n);
        more_pixels = 1'b0;
        new_pixel   = 24'($urandom);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input int stall_kind, input int stop_after);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (stop_after >= 0 && (r*W + c) >= stop_after) begin
                    more_pixels = 1'b0;
                    return;
                end
                if (stall_kind == 1 && $urandom_range(0, 3) == 0) stall($urandom_range(1, 3));
                if (stall_kind == 2 && r == 5 && c == 5) stall(7);
                new_pixel   = img[r][c];
                more_pixels = 1'b1;
                @(posedge clk);
                #1;
                if (r >= WS-1 && c >= WS-1 && pushed < int'(max_windows)) begin
                    exp_val.push_back(model_median(r, c));
                    exp_cyc.push_back(cyc + 2);
                    pushed++;
                end
            end
        end
        more_pixels = 1'b0;
    endtask

    task automatic finish_frame(input string name, input int exp_pulses, input logic exp_fin);
        int t;
        t = 0;
        while ((exp_val.size() != 0 || (exp_fin && finished !== 1'b1)) && t < 50) begin
            @(negedge clk);
            t++;
        end
        check({name, "_drain"}, exp_val.size(), 0);
        @(negedge clk);
        check({name, "_pulses"}, pulses, exp_pulses);
        check({name, "_finished"}, {31'd0, finished}, {31'd0, exp_fin});
    endtask

    task automatic do_reset(input int new_max);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("rst_ready", {31'd0, ready}, 32'd0);
        check("rst_finished", {31'd0, finished}, 32'd0);
        check("rst_median", {8'd0, median_out}, 32'd0);
        exp_val.delete();
        exp_cyc.delete();
        pushed      = 0;
        more_pixels = 1'b0;
        max_windows = new_max;
        repeat (2) @(posedge clk);
        #1;
        pulses = 0;
        rst    = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #2 rst = 1'b0;
        #10;
        check("init_ready", {31'd0, ready}, 32'd0);
        check("init_finished", {31'd0, finished}, 32'd0);
        check("init_median", {8'd0, median_out}, 32'd0);

        do_reset(NWIN);
        fill_img(0);
        run_frame(0, -1);
        finish_frame("uniform", NWIN, 1'b1);
        repeat (5) @(negedge clk);
        check("uniform_sticky", {31'd0, finished}, 32'd1);
        check("uniform_hold", {8'd0, median_out}, 32'h204060);

        do_reset(NWIN);
        fill_img(1);
        run_frame(0, -1);
        finish_frame("channels", NWIN, 1'b1);

        do_reset(NWIN);
        fill_img(3);
        run_frame(1, -1);
        finish_frame("saltpepper", NWIN, 1'b1);

        do_reset(NWIN);
        fill_img(2);
        run_frame(2, -1);
        finish_frame("stall7", NWIN, 1'b1);

        do_reset(NWIN);
        fill_img(4);
        run_frame(1, -1);
        finish_frame("ties", NWIN, 1'b1);

        do_reset(5);
        fill_img(2);
        run_frame(0, -1);
        finish_frame("limit", 5, 1'b1);
        check("limit_hold", {8'd0, median_out}, {8'd0, last_val});

        do_reset(1000);
        fill_img(2);
        run_frame(0, -1);
        more_pixels = 1'b1;
        for (int i = 0; i < 30; i++) begin
            new_pixel = 24'($urandom);
            @(posedge clk);
            #1;
        end
        more_pixels = 1'b0;
        finish_frame("overrun", NWIN, 1'b0);

        do_reset(0);
        @(negedge clk);
        check("zero_before_edge", {31'd0, finished}, 32'd0);
        @(negedge clk);
        check("zero_first_edge", {31'd0, finished}, 32'd1);
        fill_img(0);
        run_frame(0, -1);
        finish_frame("zero", 0, 1'b1);

        do_reset(NWIN);
        fill_img(2);
        run_frame(0, 7*W);
        do_reset(NWIN);
        fill_img(2);
        run_frame(0, -1);
        finish_frame("restart", NWIN, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
